// File: rtl/sigmoid_pkg.sv
// Shared types and widths for the sigmoid digit-recognizer datapath.
package sigmoid_pkg;
  localparam int MULT_IN_WIDTH  = 4;
  localparam int MULT_OUT_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} mac_state_t;
endpackage

// File: rtl/sigmoid_ALU_multiplier.sv
// 4-bit signed weight times 4-bit unsigned pixel; the product always fits in 8 signed bits.
module sigmoid_ALU_multiplier
  import sigmoid_pkg::*;
(
  input  logic [MULT_IN_WIDTH-1:0]  signval,
  input  logic [MULT_IN_WIDTH-1:0]  unsignval,
  output logic [MULT_OUT_WIDTH-1:0] out
);
  logic signed [MULT_IN_WIDTH:0]    u_ext;
  logic signed [MULT_OUT_WIDTH-1:0] prod;

  // Zero-extend the pixel so the signed multiply treats it as non-negative.
  assign u_ext = {1'b0, unsignval};
  assign prod  = $signed(signval) * u_ext;
  assign out   = prod;
endmodule

// File: rtl/sigmoid_mac_sequencer.sv
// Streams NUM_TERMS weight/pixel pairs through one shared multiplier and
// accumulates a saturating dot product, holding it until the consumer takes it.
module sigmoid_mac_sequencer
  import sigmoid_pkg::*;
#(
  parameter int NUM_TERMS = 16,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           weight,
  input  logic [3:0]           pixel,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 busy,
  output logic                 overflow
);
  localparam int CNT_W = $clog2(NUM_TERMS + 1);
  localparam logic [CNT_W-1:0]     LAST    = CNT_W'(NUM_TERMS - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  mac_state_t                    state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]          acc_q, acc_d;
  logic [MULT_IN_WIDTH-1:0]      w_q, w_d, p_q, p_d;
  logic                          pend_q, pend_d;
  logic                          ovf_q, ovf_d;
  logic [MULT_OUT_WIDTH-1:0]     prod;
  logic [ACC_WIDTH:0]            sum;
  logic                          sat;
  logic [ACC_WIDTH-1:0]          acc_sat;

  sigmoid_ALU_multiplier u_mult (
    .signval  (w_q),
    .unsignval(p_q),
    .out      (prod)
  );

  // One guard bit is enough: |product| never exceeds the accumulator range.
  assign sum     = {acc_q[ACC_WIDTH-1], acc_q}
                 + {{(ACC_WIDTH+1-MULT_OUT_WIDTH){prod[MULT_OUT_WIDTH-1]}}, prod};
  assign sat     = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
  assign acc_sat = !sat ? sum[ACC_WIDTH-1:0] : (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    w_d     = w_q;
    p_d     = p_q;
    pend_d  = 1'b0;
    ovf_d   = ovf_q;
    if (pend_q) begin
      acc_d = acc_sat;
      if (sat) ovf_d = 1'b1;
    end
    unique case (state_q)
      IDLE: if (start) begin
        state_d = ACCUM;
        cnt_d   = '0;
        acc_d   = '0;
        ovf_d   = 1'b0;
        w_d     = '0;
        p_d     = '0;
      end
      ACCUM: if (in_valid) begin
        w_d    = weight;
        p_d    = pixel;
        pend_d = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE:  if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      w_q     <= '0;
      p_q     <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
      p_q     <= p_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready     = (state_q == ACCUM);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_valid ? acc_q : '0;
  assign overflow     = ovf_q;
endmodule

// File: tb/tb_sigmoid_mac_sequencer.sv
// Bench for sigmoid_mac_sequencer: three configurations share clock and reset.
module tb_sigmoid_mac_sequencer;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic st[3], iv[3], rr[3];
  logic [3:0] wt[3], px[3];
  logic irdy[3], rv[3], bsy[3], ovf[3];
  logic [15:0] res0, res2;
  logic [7:0]  res1;

  typedef struct {
    logic signed [15:0] res;
    logic               ovf;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int d; int n; int w[4]; int p[4]; int gap; int hold; bit proto; int er; bit eo;
  } vec_t;
  vec_t tv[8];

  int cw[4], cp[4];
  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  sigmoid_mac_sequencer #(.NUM_TERMS(4), .ACC_WIDTH(16)) u0 (
    .clk(clk), .n_rst(n_rst), .start(st[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
    .weight(wt[0]), .pixel(px[0]), .result(res0), .result_valid(rv[0]),
    .result_ready(rr[0]), .busy(bsy[0]), .overflow(ovf[0]));
  sigmoid_mac_sequencer #(.NUM_TERMS(4), .ACC_WIDTH(8)) u1 (
    .clk(clk), .n_rst(n_rst), .start(st[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
    .weight(wt[1]), .pixel(px[1]), .result(res1), .result_valid(rv[1]),
    .result_ready(rr[1]), .busy(bsy[1]), .overflow(ovf[1]));
  sigmoid_mac_sequencer #(.NUM_TERMS(1), .ACC_WIDTH(16)) u2 (
    .clk(clk), .n_rst(n_rst), .start(st[2]), .in_valid(iv[2]), .in_ready(irdy[2]),
    .weight(wt[2]), .pixel(px[2]), .result(res2), .result_valid(rv[2]),
    .result_ready(rr[2]), .busy(bsy[2]), .overflow(ovf[2]));

  function automatic int res_of(input int d);
    logic signed [15:0] r;
    case (d)
      0:       r = res0;
      1:       r = {{8{res1[7]}}, res1};
      default: r = res2;
    endcase
    return int'(r);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(input int d);
    chk("rst_in_ready", int'(irdy[d]), 0);
    chk("rst_result_valid", int'(rv[d]), 0);
    chk("rst_busy", int'(bsy[d]), 0);
    chk("rst_overflow", int'(ovf[d]), 0);
    chk("rst_result", res_of(d), 0);
  endtask

  // Full transaction; the expected result is queued before any pair is driven.
  task automatic run_seq(input int d, input int n, input int gap, input int hold,
                         input bit proto, input int er, input bit eo);
    int lat;
    exp_t e;
    e.res = 16'(er);
    e.ovf = eo;
    sb.push_back(e);
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    chk("accum_ready", int'(irdy[d]), 1);
    for (int j = 0; j < n; j++) begin
      iv[d] = 1'b0;
      repeat (gap) @(negedge clk);
      iv[d] = 1'b1;
      wt[d] = 4'(cw[j]);
      px[d] = 4'(cp[j]);
      st[d] = proto;
      @(negedge clk);
    end
    iv[d] = 1'b0;
    st[d] = proto;
    lat = 1;
    while (!rv[d] && lat < 20) begin
      @(negedge clk);
      st[d] = 1'b0;
      lat++;
    end
    st[d] = 1'b0;
    chk("latency", lat, 2);
    repeat (hold) begin
      chk("hold_valid", int'(rv[d]), 1);
      chk("hold_result", res_of(d), int'(sb[0].res));
      @(negedge clk);
    end
    rr[d] = 1'b1;
    st[d] = proto;
    e = sb.pop_front();
    chk("result_valid", int'(rv[d]), 1);
    chk("result", res_of(d), int'(e.res));
    chk("overflow", int'(ovf[d]), int'(e.ovf));
    @(negedge clk);
    rr[d] = 1'b0;
    st[d] = 1'b0;
    chk("idle_after_ready", int'(bsy[d]), 0);
    chk("valid_dropped", int'(rv[d]), 0);
    if (proto) begin
      @(negedge clk);
      chk("no_restart", int'(bsy[d]), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 0; iv[i] = 0; rr[i] = 0; wt[i] = '0; px[i] = '0;
    end
    tv[0] = '{0, 4, '{7, -8, 3, -1}, '{15, 15, 2, 1}, 0, 0, 0, -10, 0};
    tv[1] = '{0, 4, '{7, -8, 3, -1}, '{15, 15, 2, 1}, 3, 5, 0, -10, 0};
    tv[2] = '{1, 4, '{-8, -8, -8, -8}, '{15, 15, 15, 15}, 0, 0, 0, -128, 1};
    tv[3] = '{1, 4, '{7, 7, 7, 7}, '{15, 15, 15, 15}, 0, 0, 0, 127, 1};
    tv[4] = '{1, 4, '{1, 1, 1, 1}, '{1, 1, 1, 1}, 0, 0, 0, 4, 0};
    tv[5] = '{0, 4, '{7, -8, 3, -1}, '{15, 15, 2, 1}, 0, 2, 1, -10, 0};
    tv[6] = '{0, 4, '{7, 7, 7, 7}, '{15, 15, 15, 15}, 1, 0, 0, 420, 0};
    tv[7] = '{2, 1, '{-8, 0, 0, 0}, '{15, 0, 0, 0}, 0, 0, 0, -120, 0};

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) chk_reset(d);
    n_rst = 1'b1;
    @(negedge clk);

    // in_valid while IDLE must not be taken
    iv[0] = 1'b1; wt[0] = 4'd7; px[0] = 4'd15;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", int'(irdy[0]), 0);
      chk("idle_busy", int'(bsy[0]), 0);
    end
    iv[0] = 1'b0;

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) begin cw[j] = tv[i].w[j]; cp[j] = tv[i].p[j]; end
      run_seq(tv[i].d, tv[i].n, tv[i].gap, tv[i].hold, tv[i].proto, tv[i].er, tv[i].eo);
    end

    // Reset in the middle of ACCUM
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    iv[0] = 1'b1; wt[0] = 4'd7; px[0] = 4'd15;
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset(0);
    n_rst = 1'b1;
    iv[0] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_valid", int'(rv[0]), 0);
      chk("post_rst_busy", int'(bsy[0]), 0);
    end

    // Every single-term product against the bench's own multiply
    for (int w = -8; w < 8; w++)
      for (int p = 0; p < 16; p++) begin
        cw[0] = w; cp[0] = p;
        run_seq(2, 1, 0, 0, 0, w * p, 0);
      end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
